rv_bus_arb: RTL and testbench
=============================

RV_BUS_ARB -- requirements
Module: rv_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles allowed per transfer before abort; legal range 1..65535.
REQ-002 SHALL have i_clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have i_reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have i_ibus_req  input  1  instruction fetch request, held until ack/err.
REQ-005 SHALL have i_ibus_adr  input  32  fetch address.
REQ-006 SHALL have o_ibus_ack  output  1  fetch done, one-cycle pulse.
REQ-007 SHALL have o_ibus_err  output  1  fetch timed out, one-cycle pulse.
REQ-008 SHALL have o_ibus_rdata  output  32  fetch data, valid with o_ibus_ack.
REQ-009 SHALL have i_dbus_req  input  1  data access request, held until ack/err.
REQ-010 SHALL have i_dbus_adr  input  32  data address.
REQ-011 SHALL have i_dbus_we  input  1  1 = store.
REQ-012 SHALL have i_dbus_sel  input  4  byte lane enables.
REQ-013 SHALL have i_dbus_wdata  input  32  store data.
REQ-014 SHALL have o_dbus_ack  output  1  data access done, one-cycle pulse.
REQ-015 SHALL have o_dbus_err  output  1  data access timed out, one-cycle pulse.
REQ-016 SHALL have o_dbus_rdata  output  32  load data, valid with o_dbus_ack.
REQ-017 SHALL have o_wb_cyc / o_wb_stb  output  1 each  Wishbone classic cycle/strobe (always equal).
REQ-018 SHALL have o_wb_adr, o_wb_dat  output  32 each  Wishbone address, write data.
REQ-019 SHALL have o_wb_we  output  1, o_wb_sel  output  4  Wishbone write enable, byte select.
REQ-020 SHALL have i_wb_dat  input  32, i_wb_ack  input  1  Wishbone read data, acknowledge.

Function
REQ-021 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; all outputs registered.
REQ-022 IDLE: requests sampled only here; only one requesting -> grant it; both -> grant port opposite to last granted (round-robin); none -> stay IDLE.
REQ-023 At grant SHALL latch adr/we/sel/wdata (fetch: we=0, sel=4'b1111, dat=0) and assert o_wb_cyc/o_wb_stb next cycle.
REQ-024 BUS: o_wb_* held stable until i_wb_ack=1; then drop cyc/stb next edge, capture i_wb_dat, enter RESP.
REQ-025 RESP: pulse granted port's ack for exactly one cycle with rdata = captured i_wb_dat (stores: captured value, don't-care); other port's ack/err remain 0.
REQ-026 Latency: req in IDLE cycle N, i_wb_ack in N+1 -> requester ack in N+3; minimum one transfer per 3 cycles.
REQ-027 Timeout: 16-bit counter cleared at grant, increments each BUS cycle; reaching TIMEOUT_CYCLES without ack -> drop cyc/stb, enter RESP, pulse err instead of ack, rdata = 0.
REQ-028 i_wb_ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as ack (ack wins).
REQ-029 Request deasserted during BUS SHALL NOT abort the transfer; ack/err still pulses.
REQ-030 Request still high in IDLE after RESP SHALL be treated as new request (round-robin applies).
REQ-031 i_wb_ack while in IDLE or RESP SHALL be ignored.

Reset
REQ-032 i_reset_n=0 at an edge SHALL force IDLE, o_wb_cyc/stb/we=0, o_wb_sel=0, o_wb_adr/dat=0, all ack/err=0, rdata=0, counter=0, last-grant=ibus (dbus wins first conflict).
REQ-033 Reset mid-BUS SHALL drop cyc/stb at that edge with no ack/err pulse.

Structure
REQ-034 Shared package rv_bus_pkg SHALL hold the FSM state enum (IDLE/BUS/RESP) and port-select typedef (PORT_I/PORT_D).
REQ-035 Timeout counter SHALL be sub-module rv_bus_timeout (clear, enable, limit -> expired).

Verification
REQ-036 Fetch only: ibus_req, adr=0x100, ack 1 cycle after cyc -> o_wb_adr=0x100, sel=1111, we=0; o_ibus_ack with rdata=0xDEADBEEF 3 cycles after req.
REQ-037 Conflict after reset: both req same cycle -> dbus granted first, then ibus; alternates on sustained conflict.
REQ-038 Store: dbus we=1, sel=0100, wdata=0x00AB0000, adr=0x2002, ack after 4 wait states -> bus fields stable all 5 BUS cycles, one o_dbus_ack.
REQ-039 Timeout: TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 BUS cycles, one o_ibus_err, rdata=0; ack on 8th cycle -> ack, no err.
REQ-040 Reset during BUS -> cyc=0 next cycle, no ack/err; then fresh request completes normally.

Source files
------------

// File: rtl/rv_bus_pkg.sv
// Shared types for the instruction/data bus arbiter: FSM states, port select and the
// round-robin pick used when both ports request in the same cycle.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } bus_port_e;

    localparam logic [3:0] FETCH_SEL = 4'b1111;

    // On conflict the port that did not win last time goes next.
    function automatic bus_port_e rr_pick(input logic ireq, input logic dreq,
                                          input bus_port_e last);
        bus_port_e pick;
        if (ireq && dreq) begin
            pick = (last == PORT_I) ? PORT_D : PORT_I;
        end else if (dreq) begin
            pick = PORT_D;
        end else begin
            pick = PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rv_bus_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the cycle in
// which the count reaches the limit.
module rv_bus_timeout (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [15:0] i_limit,
    output logic        o_expired
);

    logic [15:0] count_q;
    logic [16:0] count_inc;

    assign count_inc = {1'b0, count_q} + 17'd1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            count_q <= 16'd0;
        end else if (i_enable) begin
            count_q <= count_inc[15:0];
        end
    end

    // Combinational so the arbiter can leave BUS on the very edge the limit is reached.
    assign o_expired = i_enable && (count_inc == {1'b0, i_limit});

endmodule

// File: rtl/rv_bus_arb.sv
// Two-port (fetch/data) to single Wishbone classic master arbiter with round-robin
// conflict resolution, registered outputs and a per-transfer timeout.
module rv_bus_arb
    import rv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_ibus_req,
    input  logic [31:0] i_ibus_adr,
    output logic        o_ibus_ack,
    output logic        o_ibus_err,
    output logic [31:0] o_ibus_rdata,

    input  logic        i_dbus_req,
    input  logic [31:0] i_dbus_adr,
    input  logic        i_dbus_we,
    input  logic [3:0]  i_dbus_sel,
    input  logic [31:0] i_dbus_wdata,
    output logic        o_dbus_ack,
    output logic        o_dbus_err,
    output logic [31:0] o_dbus_rdata,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    bus_state_e  state_q;
    bus_port_e   grant_q;
    bus_port_e   pick;
    logic        resp_err_q;
    logic [31:0] cap_dat_q;
    logic        expired;

    assign pick = rr_pick(i_ibus_req, i_dbus_req, grant_q);

    rv_bus_timeout u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (state_q == IDLE),
        .i_enable  (state_q == BUS),
        .i_limit   (LIMIT),
        .o_expired (expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            grant_q      <= PORT_I;
            resp_err_q   <= 1'b0;
            cap_dat_q    <= 32'd0;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_sel     <= 4'd0;
            o_wb_adr     <= 32'd0;
            o_wb_dat     <= 32'd0;
            o_ibus_ack   <= 1'b0;
            o_ibus_err   <= 1'b0;
            o_ibus_rdata <= 32'd0;
            o_dbus_ack   <= 1'b0;
            o_dbus_err   <= 1'b0;
            o_dbus_rdata <= 32'd0;
        end else begin
            o_ibus_ack <= 1'b0;
            o_ibus_err <= 1'b0;
            o_dbus_ack <= 1'b0;
            o_dbus_err <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (i_ibus_req || i_dbus_req) begin
                        grant_q  <= pick;
                        state_q  <= BUS;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        if (pick == PORT_D) begin
                            o_wb_adr <= i_dbus_adr;
                            o_wb_we  <= i_dbus_we;
                            o_wb_sel <= i_dbus_sel;
                            o_wb_dat <= i_dbus_wdata;
                        end else begin
                            o_wb_adr <= i_ibus_adr;
                            o_wb_we  <= 1'b0;
                            o_wb_sel <= FETCH_SEL;
                            o_wb_dat <= 32'd0;
                        end
                    end
                end

                BUS: begin
                    // A slave ack in the expiry cycle still completes the transfer.
                    if (i_wb_ack) begin
                        o_wb_cyc   <= 1'b0;
                        o_wb_stb   <= 1'b0;
                        cap_dat_q  <= i_wb_dat;
                        resp_err_q <= 1'b0;
                        state_q    <= RESP;
                    end else if (expired) begin
                        o_wb_cyc   <= 1'b0;
                        o_wb_stb   <= 1'b0;
                        cap_dat_q  <= 32'd0;
                        resp_err_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end

                RESP: begin
                    if (grant_q == PORT_I) begin
                        o_ibus_ack   <= !resp_err_q;
                        o_ibus_err   <= resp_err_q;
                        o_ibus_rdata <= cap_dat_q;
                    end else begin
                        o_dbus_ack   <= !resp_err_q;
                        o_dbus_err   <= resp_err_q;
                        o_dbus_rdata <= cap_dat_q;
                    end
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_bus_arb.sv
// Self-checking bench for rv_bus_arb: directed scenarios plus a randomized run checked
// against a transaction-level timing model of the arbiter.
module tb_rv_bus_arb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ibus_req = 1'b0;
    logic [31:0] ibus_adr = 32'd0;
    logic        dbus_req = 1'b0;
    logic [31:0] dbus_adr = 32'd0;
    logic        dbus_we = 1'b0;
    logic [3:0]  dbus_sel = 4'd0;
    logic [31:0] dbus_wdata = 32'd0;
    logic [31:0] wb_dat_in = 32'd0;
    logic        wb_ack_in = 1'b0;

    logic        o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err;
    logic [31:0] o_ibus_rdata, o_dbus_rdata;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave behaviour knobs: wait states before ack (-1 = never), random acks while idle.
    int          slv_wait = 0;
    bit          slv_spurious = 0;
    bit          slv_use_fixed = 0;
    logic [31:0] slv_fixed = 32'd0;
    int          slv_cnt = 0;

    rv_bus_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_ibus_req   (ibus_req),
        .i_ibus_adr   (ibus_adr),
        .o_ibus_ack   (o_ibus_ack),
        .o_ibus_err   (o_ibus_err),
        .o_ibus_rdata (o_ibus_rdata),
        .i_dbus_req   (dbus_req),
        .i_dbus_adr   (dbus_adr),
        .i_dbus_we    (dbus_we),
        .i_dbus_sel   (dbus_sel),
        .i_dbus_wdata (dbus_wdata),
        .o_dbus_ack   (o_dbus_ack),
        .o_dbus_err   (o_dbus_err),
        .o_dbus_rdata (o_dbus_rdata),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_adr     (o_wb_adr),
        .o_wb_dat     (o_wb_dat),
        .o_wb_we      (o_wb_we),
        .o_wb_sel     (o_wb_sel),
        .i_wb_dat     (wb_dat_in),
        .i_wb_ack     (wb_ack_in)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_dat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    initial forever begin
        @(negedge clk);
        if (o_wb_cyc === 1'b1) begin
            wb_ack_in = (slv_wait >= 0) && (slv_cnt == slv_wait);
            wb_dat_in = slv_use_fixed ? slv_fixed : mem_dat(o_wb_adr);
            slv_cnt++;
        end else begin
            slv_cnt   = 0;
            wb_ack_in = slv_spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_dat_in = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        ibus_req     = 1'b1;
        ibus_adr     = 32'h1234_5678;
        dbus_req     = 1'b1;
        dbus_adr     = 32'h8765_4321;
        dbus_we      = 1'b1;
        dbus_sel     = 4'hF;
        dbus_wdata   = 32'hFFFF_FFFF;
        slv_spurious = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 000", {o_wb_cyc, o_wb_stb, o_wb_we});
        end
        n_cmp++;
        if (o_wb_sel !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_sel: got %h want 0", o_wb_sel);
        end
        n_cmp++;
        if ({o_wb_adr, o_wb_dat} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_adr_dat: got %h/%h want 0/0", o_wb_adr, o_wb_dat);
        end
        n_cmp++;
        if ({o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_resp: got %b want 0000",
                     {o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err});
        end
        n_cmp++;
        if ({o_ibus_rdata, o_dbus_rdata} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", o_ibus_rdata, o_dbus_rdata);
        end
        reset_n      = 1'b1;
        ibus_req     = 1'b0;
        dbus_req     = 1'b0;
        slv_spurious = 1'b0;
    endtask

    task automatic test_fetch();
        slv_use_fixed = 1'b1;
        slv_fixed     = 32'hDEAD_BEEF;
        slv_wait      = 0;
        tick();
        ibus_req = 1'b1;
        ibus_adr = 32'h100;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel} !== 7'b1101111) begin
            n_bad++;
            $display("FAIL fetch_ctl: got %b want 1101111",
                     {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel});
        end
        n_cmp++;
        if (o_wb_adr !== 32'h100) begin
            n_bad++;
            $display("FAIL fetch_adr: got %h want 00000100", o_wb_adr);
        end
        n_cmp++;
        if (o_wb_dat !== 32'h0) begin
            n_bad++;
            $display("FAIL fetch_dat: got %h want 0", o_wb_dat);
        end
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_ibus_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL fetch_resp_cycle: cyc/ack got %b want 00", {o_wb_cyc, o_ibus_ack});
        end
        tick();
        n_cmp++;
        if ({o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err} !== 4'b1000) begin
            n_bad++;
            $display("FAIL fetch_ack: got %b want 1000",
                     {o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err});
        end
        n_cmp++;
        if (o_ibus_rdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL fetch_rdata: got %h want deadbeef", o_ibus_rdata);
        end
        ibus_req = 1'b0;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_ibus_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL fetch_after: cyc/ack got %b want 00", {o_wb_cyc, o_ibus_ack});
        end
        slv_use_fixed = 1'b0;
    endtask

    task automatic test_conflict();
        bit want_d;
        do_reset();
        tick();
        ibus_req   = 1'b1;
        ibus_adr   = 32'h1000;
        dbus_req   = 1'b1;
        dbus_adr   = 32'h2000;
        dbus_we    = 1'b0;
        dbus_sel   = 4'hF;
        dbus_wdata = 32'h0;
        slv_wait   = 0;
        for (int k = 0; k < 4; k++) begin
            want_d = (k % 2 == 0);
            tick();
            n_cmp++;
            if (o_wb_cyc !== 1'b1 || o_wb_adr !== (want_d ? 32'h2000 : 32'h1000)) begin
                n_bad++;
                $display("FAIL conflict_grant[%0d]: cyc=%b adr=%h want cyc=1 adr=%h", k,
                         o_wb_cyc, o_wb_adr, want_d ? 32'h2000 : 32'h1000);
            end
            tick();
            tick();
            n_cmp++;
            if ({o_ibus_ack, o_dbus_ack} !== (want_d ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL conflict_ack[%0d]: i/d ack got %b want %b", k,
                         {o_ibus_ack, o_dbus_ack}, want_d ? 2'b01 : 2'b10);
            end
        end
        ibus_req = 1'b0;
        dbus_req = 1'b0;
    endtask

    task automatic test_store();
        int extra;
        tick();
        dbus_req   = 1'b1;
        dbus_we    = 1'b1;
        dbus_sel   = 4'b0100;
        dbus_wdata = 32'h00AB_0000;
        dbus_adr   = 32'h2002;
        slv_wait   = 4;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat} !==
                {3'b111, 4'b0100, 32'h2002, 32'h00AB_0000}) begin
                n_bad++;
                $display("FAIL store_bus[%0d]: got %b %h %h %h want 111 4 00002002 00ab0000", k,
                         {o_wb_cyc, o_wb_stb, o_wb_we}, o_wb_sel, o_wb_adr, o_wb_dat);
            end
        end
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_dbus_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL store_resp_cycle: cyc/ack got %b want 00", {o_wb_cyc, o_dbus_ack});
        end
        tick();
        n_cmp++;
        if ({o_dbus_ack, o_dbus_err, o_ibus_ack, o_ibus_err} !== 4'b1000) begin
            n_bad++;
            $display("FAIL store_ack: got %b want 1000",
                     {o_dbus_ack, o_dbus_err, o_ibus_ack, o_ibus_err});
        end
        dbus_req = 1'b0;
        extra = 0;
        repeat (4) begin
            tick();
            extra += int'(o_dbus_ack) + int'(o_dbus_err) + int'(o_wb_cyc);
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL store_extra: got %0d stray cyc/ack/err cycles want 0", extra);
        end
    endtask

    task automatic test_timeout();
        int cyc_n, err_n, ack_n, hit_at;
        // Part 1: slave never acks.
        tick();
        ibus_req = 1'b1;
        ibus_adr = 32'h300;
        slv_wait = -1;
        cyc_n = 0; err_n = 0; ack_n = 0; hit_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            cyc_n += int'(o_wb_cyc);
            ack_n += int'(o_ibus_ack) + int'(o_dbus_ack) + int'(o_dbus_err);
            if (o_ibus_err === 1'b1) begin
                err_n++;
                hit_at = k;
                ibus_req = 1'b0;
                n_cmp++;
                if (o_ibus_rdata !== 32'h0) begin
                    n_bad++;
                    $display("FAIL timeout_rdata: got %h want 0", o_ibus_rdata);
                end
            end
        end
        n_cmp++;
        if (cyc_n != TO || err_n != 1 || hit_at != TO + 2 || ack_n != 0) begin
            n_bad++;
            $display("FAIL timeout_abort: cyc=%0d err=%0d at=%0d ack=%0d want %0d 1 %0d 0",
                     cyc_n, err_n, hit_at, ack_n, TO, TO + 2);
        end
        // Part 2: ack lands on the last allowed bus cycle.
        ibus_req = 1'b0;
        tick();
        ibus_req = 1'b1;
        ibus_adr = 32'h304;
        slv_wait = TO - 1;
        cyc_n = 0; err_n = 0; ack_n = 0; hit_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            cyc_n += int'(o_wb_cyc);
            err_n += int'(o_ibus_err) + int'(o_dbus_err);
            if (o_ibus_ack === 1'b1) begin
                ack_n++;
                hit_at = k;
                ibus_req = 1'b0;
                n_cmp++;
                if (o_ibus_rdata !== mem_dat(32'h304)) begin
                    n_bad++;
                    $display("FAIL timeout_edge_rdata: got %h want %h", o_ibus_rdata,
                             mem_dat(32'h304));
                end
            end
        end
        n_cmp++;
        if (cyc_n != TO || ack_n != 1 || hit_at != TO + 2 || err_n != 0) begin
            n_bad++;
            $display("FAIL timeout_edge_ack: cyc=%0d ack=%0d at=%0d err=%0d want %0d 1 %0d 0",
                     cyc_n, ack_n, hit_at, err_n, TO, TO + 2);
        end
        ibus_req = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        int hits, errs, hit_at;
        tick();
        dbus_req = 1'b1;
        dbus_adr = 32'h400;
        dbus_we  = 1'b0;
        dbus_sel = 4'h3;
        slv_wait = -1;
        tick();
        tick();
        n_cmp++;
        if (o_wb_cyc !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_busy: cyc got %b want 1", o_wb_cyc);
        end
        reset_n = 1'b0;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_stb, o_dbus_ack, o_dbus_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset_drop: cyc/stb/ack/err got %b want 0000",
                     {o_wb_cyc, o_wb_stb, o_dbus_ack, o_dbus_err});
        end
        reset_n  = 1'b1;
        slv_wait = 2;
        hits = 0; errs = 0; hit_at = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                // Requester withdraws mid-transfer; the transfer must still finish.
                dbus_req = 1'b0;
                n_cmp++;
                if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h400 || o_wb_sel !== 4'h3) begin
                    n_bad++;
                    $display("FAIL midreset_regrant: cyc=%b adr=%h sel=%h want 1 400 3",
                             o_wb_cyc, o_wb_adr, o_wb_sel);
                end
            end
            errs += int'(o_dbus_err) + int'(o_ibus_err) + int'(o_ibus_ack);
            if (o_dbus_ack === 1'b1) begin
                hits++;
                hit_at = k;
                n_cmp++;
                if (o_dbus_rdata !== mem_dat(32'h400)) begin
                    n_bad++;
                    $display("FAIL midreset_rdata: got %h want %h", o_dbus_rdata,
                             mem_dat(32'h400));
                end
            end
        end
        n_cmp++;
        if (hits != 1 || hit_at != 5 || errs != 0) begin
            n_bad++;
            $display("FAIL midreset_resume: acks=%0d at=%0d others=%0d want 1 5 0",
                     hits, hit_at, errs);
        end
    endtask

    // Transaction-level model: a grant at cycle g with w wait states occupies the bus for
    // min(w+1, TO) cycles and responds two cycles after the bus phase starts ending.
    task automatic test_random(input int n_cycles);
        bit          active, m_port, m_err, last_d;
        int          g, len, w;
        logic [31:0] m_adr, m_dat;
        logic        m_we;
        logic [3:0]  m_sel;
        logic [5:0]  exp_ctl, got_ctl;

        do_reset();
        slv_spurious = 1'b1;
        slv_use_fixed = 1'b0;
        active = 1'b0;
        last_d = 1'b0;
        g = 0; len = 0; m_port = 1'b0; m_err = 1'b0;
        m_adr = '0; m_dat = '0; m_we = 1'b0; m_sel = '0;
        for (int t = 0; t < n_cycles; t++) begin
            tick();
            exp_ctl[5] = active && (t > g) && (t <= g + len);
            exp_ctl[4] = exp_ctl[5];
            exp_ctl[3] = active && (t == g + len + 2) && !m_port && !m_err;
            exp_ctl[2] = active && (t == g + len + 2) && !m_port && m_err;
            exp_ctl[1] = active && (t == g + len + 2) && m_port && !m_err;
            exp_ctl[0] = active && (t == g + len + 2) && m_port && m_err;
            got_ctl = {o_wb_cyc, o_wb_stb, o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err};
            n_cmp++;
            if (got_ctl !== exp_ctl) begin
                n_bad++;
                $display("FAIL rand_ctl[t=%0d]: cyc/stb/ia/ie/da/de got %b want %b",
                         t, got_ctl, exp_ctl);
            end
            if (exp_ctl[5]) begin
                n_cmp++;
                if ({o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat} !== {m_adr, m_we, m_sel, m_dat})
                begin
                    n_bad++;
                    $display("FAIL rand_bus[t=%0d]: got %h %b %h %h want %h %b %h %h", t,
                             o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat, m_adr, m_we, m_sel, m_dat);
                end
            end
            if (exp_ctl[3] || (exp_ctl[1] && !m_we)) begin
                n_cmp++;
                if ((m_port ? o_dbus_rdata : o_ibus_rdata) !== mem_dat(m_adr)) begin
                    n_bad++;
                    $display("FAIL rand_rdata[t=%0d]: got %h want %h", t,
                             m_port ? o_dbus_rdata : o_ibus_rdata, mem_dat(m_adr));
                end
            end
            if (exp_ctl[2] || exp_ctl[0]) begin
                n_cmp++;
                if ((m_port ? o_dbus_rdata : o_ibus_rdata) !== 32'h0) begin
                    n_bad++;
                    $display("FAIL rand_err_rdata[t=%0d]: got %h want 0", t,
                             m_port ? o_dbus_rdata : o_ibus_rdata);
                end
            end

            // Completing requester either withdraws or immediately asks again.
            if (active && t == g + len + 2) begin
                active = 1'b0;
                if (m_port) begin
                    dbus_req = 1'($urandom_range(0, 1));
                    dbus_adr = $urandom; dbus_we = 1'($urandom_range(0, 1));
                    dbus_sel = 4'($urandom); dbus_wdata = $urandom;
                end else begin
                    ibus_req = 1'($urandom_range(0, 1));
                    ibus_adr = $urandom;
                end
            end
            if (!ibus_req && $urandom_range(0, 2) == 0) begin
                ibus_req = 1'b1;
                ibus_adr = $urandom;
            end
            if (!dbus_req && $urandom_range(0, 2) == 0) begin
                dbus_req = 1'b1;
                dbus_adr = $urandom; dbus_we = 1'($urandom_range(0, 1));
                dbus_sel = 4'($urandom); dbus_wdata = $urandom;
            end

            if (!active && (ibus_req || dbus_req)) begin
                m_port = (ibus_req && dbus_req) ? !last_d : dbus_req;
                last_d = m_port;
                if (m_port) begin
                    m_adr = dbus_adr; m_we = dbus_we; m_sel = dbus_sel; m_dat = dbus_wdata;
                end else begin
                    m_adr = ibus_adr; m_we = 1'b0; m_sel = 4'hF; m_dat = 32'h0;
                end
                w = int'($urandom_range(0, 10));
                slv_wait = w;
                len = (w + 1 <= TO) ? w + 1 : TO;
                m_err = (w + 1 > TO);
                g = t;
                active = 1'b1;
            end
        end
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        slv_spurious = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_timeout();
        test_reset_mid_bus();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
